// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: controller state enum, default drain length, x0 register index.
package pipe_pkg;

  // Cycles a break/trap needs after leaving ID to retire through EX, MEM, WB.
  localparam int PIPE_DRAIN_CYCLES = 3;

  // Width of the drain down-counter; comfortably covers any realistic depth.
  localparam int DRAIN_CNT_W = 8;

  // Hard-wired zero register; never a forwarding or hazard source.
  localparam logic [4:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_fwd.sv
// Per-operand forwarding match: decides whether an EX-stage source comes from EX/MEM or MEM/WB.
// Latency: purely combinational; the caller registers the result on ID/EX advance.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   i_rs_addr / i_rs_used          ID source register and whether it is read
//   i_ex_rd_waddr / _wen / _mem_read   producer currently in EX
//   i_mem_rd_waddr / _wen          producer currently in MEM
//   o_alu_nxt / o_mem_nxt          forward-from-ALU / forward-from-MEM for next cycle
module pipe_fwd
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs_addr,
  input  logic       i_rs_used,
  input  logic [4:0] i_ex_rd_waddr,
  input  logic       i_ex_rd_wen,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_mem_rd_waddr,
  input  logic       i_mem_rd_wen,
  output logic       o_alu_nxt,
  output logic       o_mem_nxt
);

  always_comb begin
    // A load in EX has no ALU result to forward; that case is a load-use stall instead.
    o_alu_nxt = i_rs_used & i_ex_rd_wen & ~i_ex_mem_read &
                (i_ex_rd_waddr != X0) & (i_ex_rd_waddr == i_rs_addr);
    // The younger producer (EX) wins when both stages write the same register.
    o_mem_nxt = i_rs_used & i_mem_rd_wen & (i_mem_rd_waddr != X0) &
                (i_mem_rd_waddr == i_rs_addr) & ~o_alu_nxt;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage-register holds/flushes, registered EX forwarding selects,
// Latency: holds/flushes combinational (same cycle); forwarding selects and o_halted one cycle.
// Backpressure: i_dmem_busy freezes every stage register, the drain counter and forwarding flags.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_id_*                           decoded ID instruction (valid, sources, halt)
//   i_ex_*, i_mem_*                  destinations of the EX and MEM instructions, redirect
//   i_dmem_busy                      data memory not ready
//   o_*_hold, o_*_flush              stage-register controls
//   o_frwd_*                         registered EX operand selects
//   o_halted                         core stopped after break/trap retired
//   o_stall_cnt, o_flush_cnt         performance counters
// Optional feature macro: PIPE_CTRL_PERF_EN enables the two performance counters;
// without it both counter outputs are constant zero.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = PIPE_DRAIN_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_vld,
  input  logic [4:0]  i_id_rs1_raddr,
  input  logic [4:0]  i_id_rs2_raddr,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic        i_id_halt,
  input  logic [4:0]  i_ex_rd_waddr,
  input  logic        i_ex_rd_wen,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_redirect,
  input  logic [4:0]  i_mem_rd_waddr,
  input  logic        i_mem_rd_wen,
  input  logic        i_dmem_busy,
  output logic        o_pc_hold,
  output logic        o_if_id_hold,
  output logic        o_id_ex_hold,
  output logic        o_ex_mem_hold,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_frwd_alu_op1,
  output logic        o_frwd_alu_op2,
  output logic        o_frwd_mem_op1,
  output logic        o_frwd_mem_op2,
  output logic        o_halted,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LD = DRAIN_CNT_W'(DRAIN_CYCLES);

  pipe_state_e state_q, state_d;
  // State to resume after a data-memory stall (only RUN or DRAIN are ever saved).
  pipe_state_e saved_q, saved_d;
  pipe_state_e eff_state;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  // Forwarding flags packed as {alu_op1, alu_op2, mem_op1, mem_op2}.
  logic [3:0] frwd_q, frwd_d;
  logic       alu1_nxt, alu2_nxt, mem1_nxt, mem2_nxt;
  logic       load_use;

  pipe_fwd u_fwd_op1 (
    .i_rs_addr      (i_id_rs1_raddr),
    .i_rs_used      (i_id_rs1_used),
    .i_ex_rd_waddr  (i_ex_rd_waddr),
    .i_ex_rd_wen    (i_ex_rd_wen),
    .i_ex_mem_read  (i_ex_mem_read),
    .i_mem_rd_waddr (i_mem_rd_waddr),
    .i_mem_rd_wen   (i_mem_rd_wen),
    .o_alu_nxt      (alu1_nxt),
    .o_mem_nxt      (mem1_nxt)
  );

  pipe_fwd u_fwd_op2 (
    .i_rs_addr      (i_id_rs2_raddr),
    .i_rs_used      (i_id_rs2_used),
    .i_ex_rd_waddr  (i_ex_rd_waddr),
    .i_ex_rd_wen    (i_ex_rd_wen),
    .i_ex_mem_read  (i_ex_mem_read),
    .i_mem_rd_waddr (i_mem_rd_waddr),
    .i_mem_rd_wen   (i_mem_rd_wen),
    .o_alu_nxt      (alu2_nxt),
    .o_mem_nxt      (mem2_nxt)
  );

  always_comb begin
    load_use = i_id_vld & i_ex_mem_read & i_ex_rd_wen & (i_ex_rd_waddr != X0) &
               ((i_id_rs1_used & (i_id_rs1_raddr == i_ex_rd_waddr)) |
                (i_id_rs2_used & (i_id_rs2_raddr == i_ex_rd_waddr)));
  end

  // Next-state and stage controls.
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    drain_cnt_d   = drain_cnt_q;
    o_pc_hold     = 1'b0;
    o_if_id_hold  = 1'b0;
    o_id_ex_hold  = 1'b0;
    o_ex_mem_hold = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    // Once a stall clears, the cycle behaves as the state it interrupted.
    eff_state     = (state_q == DMEM_WAIT) ? saved_q : state_q;

    if (state_q == HALTED) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_hold  = 1'b1;
      o_ex_mem_hold = 1'b1;
    end else if (i_dmem_busy) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_hold  = 1'b1;
      o_ex_mem_hold = 1'b1;
      state_d       = DMEM_WAIT;
      if (state_q != DMEM_WAIT) begin
        saved_d = state_q;
      end
    end else begin
      state_d = eff_state;
      if (eff_state == DRAIN) begin
        // Stop fetch and keep bubbling ID while the break/trap retires.
        o_pc_hold     = 1'b1;
        o_if_id_flush = 1'b1;
        if (drain_cnt_q <= DRAIN_CNT_W'(1)) begin
          drain_cnt_d = '0;
          state_d     = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
        end
      end else if (i_ex_redirect) begin
        // ID and IF hold wrong-path work, so any stall or halt there is moot.
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (load_use) begin
        o_pc_hold     = 1'b1;
        o_if_id_hold  = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (i_id_halt & i_id_vld) begin
        if (DRAIN_LD == '0) begin
          state_d = HALTED;
        end else begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LD;
        end
      end
    end
  end

  always_comb begin
    frwd_d = frwd_q;
    if (o_id_ex_flush) begin
      frwd_d = 4'b0000;
    end else if (!o_id_ex_hold) begin
      frwd_d = {alu1_nxt, alu2_nxt, mem1_nxt, mem2_nxt};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      drain_cnt_q <= '0;
      frwd_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      drain_cnt_q <= drain_cnt_d;
      frwd_q      <= frwd_d;
    end
  end

  assign o_frwd_alu_op1 = frwd_q[3];
  assign o_frwd_alu_op2 = frwd_q[2];
  assign o_frwd_mem_op1 = frwd_q[1];
  assign o_frwd_mem_op2 = frwd_q[0];
  assign o_halted       = (state_q == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Events are recovered from the stage controls: a load-use stall is the only case with
  // pc_hold plus id_ex_flush, a redirect the only one flushing both registers.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED) begin
      if (i_dmem_busy | (o_pc_hold & o_id_ex_flush)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (o_if_id_flush & o_id_ex_flush) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of per-cycle vectors plus hand sequences for
// data-memory stalls, break drain-to-halt and reset during drain.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        i_clk, i_rst_n;
  logic        i_id_vld, i_id_rs1_used, i_id_rs2_used, i_id_halt;
  logic [4:0]  i_id_rs1_raddr, i_id_rs2_raddr;
  logic [4:0]  i_ex_rd_waddr, i_mem_rd_waddr;
  logic        i_ex_rd_wen, i_ex_mem_read, i_ex_redirect, i_mem_rd_wen, i_dmem_busy;
  logic        o_pc_hold, o_if_id_hold, o_id_ex_hold, o_ex_mem_hold;
  logic        o_if_id_flush, o_id_ex_flush;
  logic        o_frwd_alu_op1, o_frwd_alu_op2, o_frwd_mem_op1, o_frwd_mem_op2;
  logic        o_halted;
  logic [31:0] o_stall_cnt, o_flush_cnt;

  pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_vld(i_id_vld), .i_id_rs1_raddr(i_id_rs1_raddr), .i_id_rs2_raddr(i_id_rs2_raddr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used), .i_id_halt(i_id_halt),
    .i_ex_rd_waddr(i_ex_rd_waddr), .i_ex_rd_wen(i_ex_rd_wen), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_redirect(i_ex_redirect), .i_mem_rd_waddr(i_mem_rd_waddr), .i_mem_rd_wen(i_mem_rd_wen),
    .i_dmem_busy(i_dmem_busy),
    .o_pc_hold(o_pc_hold), .o_if_id_hold(o_if_id_hold), .o_id_ex_hold(o_id_ex_hold),
    .o_ex_mem_hold(o_ex_mem_hold), .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_frwd_alu_op1(o_frwd_alu_op1), .o_frwd_alu_op2(o_frwd_alu_op2),
    .o_frwd_mem_op1(o_frwd_mem_op1), .o_frwd_mem_op2(o_frwd_mem_op2),
    .o_halted(o_halted), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2;
    logic       u1, u2, halt;
    logic [4:0] ex_rd;
    logic       ex_wen, ex_ld, redir;
    logic [4:0] mem_rd;
    logic       mem_wen, busy;
    logic [3:0] e_hold;   // {pc, if_id, id_ex, ex_mem}
    logic [1:0] e_flush;  // {if_id, id_ex}
    logic [3:0] e_fwd;    // {alu1, alu2, mem1, mem2}
    logic       e_halted;
    int         e_stall, e_flc;
  } vec_t;

  int n_vec;
  int n_miss;
  int exp_stall;

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic halt,
                              input logic [4:0] ex_rd, input logic ex_wen, input logic ex_ld,
                              input logic redir, input logic [4:0] mem_rd, input logic mem_wen,
                              input logic busy, input logic [3:0] e_hold, input logic [1:0] e_flush,
                              input logic [3:0] e_fwd, input logic e_halted,
                              input int e_stall, input int e_flc);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.halt = halt;
    v.ex_rd = ex_rd; v.ex_wen = ex_wen; v.ex_ld = ex_ld; v.redir = redir;
    v.mem_rd = mem_rd; v.mem_wen = mem_wen; v.busy = busy;
    v.e_hold = e_hold; v.e_flush = e_flush; v.e_fwd = e_fwd; v.e_halted = e_halted;
    v.e_stall = e_stall; v.e_flc = e_flc;
    return v;
  endfunction

  function automatic logic [31:0] ecnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic drv(input vec_t v);
    i_id_vld = v.vld; i_id_rs1_raddr = v.rs1; i_id_rs2_raddr = v.rs2;
    i_id_rs1_used = v.u1; i_id_rs2_used = v.u2; i_id_halt = v.halt;
    i_ex_rd_waddr = v.ex_rd; i_ex_rd_wen = v.ex_wen; i_ex_mem_read = v.ex_ld;
    i_ex_redirect = v.redir; i_mem_rd_waddr = v.mem_rd; i_mem_rd_wen = v.mem_wen;
    i_dmem_busy = v.busy;
  endtask

  task automatic idle();
    drv(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0, 4'b0,2'b0,4'b0,0,0,0));
  endtask

  function automatic logic [74:0] outs();
    return {o_pc_hold, o_if_id_hold, o_id_ex_hold, o_ex_mem_hold, o_if_id_flush, o_id_ex_flush,
            o_frwd_alu_op1, o_frwd_alu_op2, o_frwd_mem_op1, o_frwd_mem_op2, o_halted,
            o_stall_cnt, o_flush_cnt};
  endfunction

  function automatic logic [6:0] ctl();
    return {o_pc_hold, o_if_id_hold, o_id_ex_hold, o_ex_mem_hold, o_if_id_flush, o_id_ex_flush,
            o_halted};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    n_vec = 0;
    n_miss = 0;
    //            vld rs1 rs2 u1 u2 hlt exrd wen ld rdr memrd mwen busy  hold   flush fwd    hlt stl flc
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 5, 1, 1, 1, 0,  5, 1, 1, 0,  0, 0, 0, 4'b1100, 2'b01, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(1, 5, 1, 1, 1, 0,  0, 0, 0, 0,  5, 1, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0,  6, 1, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0010, 0, 1, 0);
    tbl[4]  = mk(1, 3, 3, 1, 1, 0,  3, 1, 0, 0,  6, 1, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0);
    tbl[5]  = mk(1, 4, 3, 1, 1, 0,  4, 1, 0, 0,  3, 1, 0, 4'b0000, 2'b00, 4'b1100, 0, 1, 0);
    tbl[6]  = mk(1, 7, 7, 1, 1, 0,  7, 1, 0, 0,  7, 1, 0, 4'b0000, 2'b00, 4'b1001, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 1, 1, 0,  0, 1, 0, 0,  0, 1, 0, 4'b0000, 2'b00, 4'b1100, 0, 1, 0);
    tbl[8]  = mk(1, 9, 9, 0, 0, 0,  9, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0);
    tbl[9]  = mk(1, 5, 0, 1, 0, 0,  5, 1, 1, 1,  0, 0, 0, 4'b0000, 2'b11, 4'b0000, 0, 1, 0);
    tbl[10] = mk(1, 2, 0, 1, 0, 0,  2, 1, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 4'b1111, 2'b00, 4'b1000, 0, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b1000, 0, 2, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 2, 1);
    tbl[14] = mk(0, 5, 0, 1, 0, 0,  5, 1, 1, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 2, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 2, 1);

    // Reset state while reset is held.
    i_rst_n = 1'b0;
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_state", 96'(outs()), 96'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    next_cycle();

    // Table: each vector is one cycle; outputs sampled on the falling edge.
    for (int i = 0; i < 16; i++) begin
      drv(tbl[i]);
      @(negedge i_clk);
      chk($sformatf("vec%0d", i), 96'(outs()),
          96'({tbl[i].e_hold, tbl[i].e_flush, tbl[i].e_fwd, tbl[i].e_halted,
               ecnt(tbl[i].e_stall), ecnt(tbl[i].e_flc)}));
      next_cycle();
    end
    exp_stall = 2;

    // Data memory busy for 4 cycles on top of a load-use stall.
    for (int k = 0; k < 4; k++) begin
      drv(mk(1, 0, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 4'b0,2'b0,4'b0,0,0,0));
      @(negedge i_clk);
      chk($sformatf("busy_lu_%0d", k), 96'(ctl()), 96'(7'b1111_00_0));
      next_cycle();
    end
    drv(mk(1, 0, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 4'b0,2'b0,4'b0,0,0,0));
    @(negedge i_clk);
    chk("lu_after_busy", 96'(ctl()), 96'(7'b1100_01_0));
    next_cycle();
    exp_stall += 5;
    idle();
    @(negedge i_clk);
    chk("stall_cnt_busy", 96'(o_stall_cnt), 96'(ecnt(exp_stall)));
    chk("lu_done", 96'(ctl()), 96'd0);
    next_cycle();

    // Break in ID at t, busy at t+2, halted expected at t+5.
    drv(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0,2'b0,4'b0,0,0,0));
    @(negedge i_clk);
    chk("brk_t0", 96'(ctl()), 96'd0);
    next_cycle();
    idle();
    @(negedge i_clk);
    chk("brk_t1", 96'(ctl()), 96'(7'b1000_10_0));
    next_cycle();
    i_dmem_busy = 1'b1;
    @(negedge i_clk);
    chk("brk_t2_busy", 96'(ctl()), 96'(7'b1111_00_0));
    next_cycle();
    exp_stall += 1;
    i_dmem_busy = 1'b0;
    @(negedge i_clk);
    chk("brk_t3", 96'(ctl()), 96'(7'b1000_10_0));
    next_cycle();
    @(negedge i_clk);
    chk("brk_t4", 96'(ctl()), 96'(7'b1000_10_0));
    next_cycle();
    @(negedge i_clk);
    chk("brk_t5_halted", 96'(ctl()), 96'(7'b1111_00_1));
    next_cycle();
    i_ex_redirect = 1'b1;
    i_dmem_busy = 1'b1;
    @(negedge i_clk);
    chk("halted_sticky", 96'(ctl()), 96'(7'b1111_00_1));
    next_cycle();
    idle();
    @(negedge i_clk);
    chk("halted_cnt_frozen", 96'({o_halted, o_stall_cnt}), 96'({1'b1, ecnt(exp_stall)}));
    next_cycle();

    // Reset exits HALTED asynchronously and clears the counters.
    i_rst_n = 1'b0;
    #1;
    chk("rst_from_halt", 96'(ctl()), 96'd0);
    @(negedge i_clk);
    chk("rst_cnt", 96'({o_stall_cnt, o_flush_cnt}), 96'd0);
    i_rst_n = 1'b1;
    next_cycle();

    // Reset asserted mid-DRAIN, between clock edges.
    drv(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0,2'b0,4'b0,0,0,0));
    @(negedge i_clk);
    next_cycle();
    idle();
    @(negedge i_clk);
    chk("drain_before_rst", 96'(ctl()), 96'(7'b1000_10_0));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_in_drain", 96'(ctl()), 96'd0);
    next_cycle();
    i_rst_n = 1'b1;
    drv(mk(1, 2, 3, 1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 4'b0,2'b0,4'b0,0,0,0));
    @(negedge i_clk);
    chk("post_rst_flow", 96'(ctl()), 96'd0);
    next_cycle();
    idle();
    @(negedge i_clk);
    chk("post_rst_next", 96'({ctl(), o_frwd_alu_op1, o_frwd_alu_op2, o_frwd_mem_op1,
                              o_frwd_mem_op2}), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
